axi4_frame_mem_slave: RTL
=========================

Name: axi4_frame_mem_slave

Overview:
- Single-clock AXI4 slave (responder) backed by an internal 64-bit word memory.
- Terminates both the camera-path write master and the HDMI-path read master on the 100 MHz AXI clock.
- Stands in for the PS HP0/HP1 + DDR path in simulation and in PL-only bring-up builds.
- Independent write and read channels share one dual-port memory array.

Parameters:
- BASE_ADDR, 32'h1000_0000, byte address that maps to word 0.
- DEPTH_LOG2, 14, log2 of memory depth in 64-bit words (16384 words = 128 KiB).
- INIT_VAL, 64'h0, value held by every word after configuration (not re-applied on rst).

Ports:
- clk_100Mhz  in  1  AXI clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- AWADDR  in  32  write burst byte address.
- AWVALID  in  1  write address valid.
- AWREADY  out  1  write address ready.
- AWLEN  in  8  write beats minus 1.
- AWSIZE  in  3  write beat size; 3'b011 expected.
- AWBURST  in  2  write burst type; INCR (2'b01) expected.
- WDATA  in  64  write data.
- WSTRB  in  8  byte enables.
- WVALID  in  1  write data valid.
- WREADY  out  1  write data ready.
- WLAST  in  1  last write beat.
- BRESP  out  2  write response; always 2'b00.
- BVALID  out  1  write response valid.
- BREADY  in  1  write response ready.
- ARADDR  in  32  read burst byte address.
- ARVALID  in  1  read address valid.
- ARREADY  out  1  read address ready.
- ARLEN  in  8  read beats minus 1.
- ARSIZE  in  3  read beat size; 3'b011 expected.
- ARBURST  in  2  read burst type; INCR expected.
- RDATA  out  64  read data.
- RRESP  out  2  read response; always 2'b00.
- RVALID  out  1  read data valid.
- RREADY  in  1  read data ready.
- RLAST  out  1  last read beat.
- err_flags  out  4  sticky error flags: [0] WLAST early, [1] WLAST missing, [2] bad size/burst, [3] address out of range.

Behaviour:
- Reset values:
  - AWREADY=1, ARREADY=1; WREADY, BVALID, RVALID, RLAST = 0.
  - RDATA=0, BRESP=RRESP=0, err_flags=0.
  - Memory contents are not touched by rst.
- Word index: idx = (addr - BASE_ADDR) >> 3, truncated to DEPTH_LOG2 bits, so addresses wrap modulo the depth.
  - err_flags[3] sets if (addr - BASE_ADDR) >> 3 >= 2^DEPTH_LOG2, or if addr < BASE_ADDR. The burst still completes.
  - The index increments by 1 per beat and wraps at 2^DEPTH_LOG2 - 1 -> 0. No 4 KiB boundary check.
- Write FSM: W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: AWREADY=1. An AWVALID&&AWREADY handshake latches idx and AWLEN, clears the beat counter, and moves to W_DATA. AWREADY=0 outside W_IDLE.
  - W_DATA: WREADY=1. Each WVALID&&WREADY writes the bytes of mem[idx] enabled by WSTRB, then idx++ and cnt++.
    - If WLAST=1 before cnt==len, set err_flags[0] and go to W_RESP.
    - If cnt==len and WLAST=0, set err_flags[1] and go to W_RESP anyway; further W beats are ignored until the next AW.
    - Correct case: WLAST=1 with cnt==len goes to W_RESP.
  - W_RESP: BVALID=1 until BVALID&&BREADY, then W_IDLE. The earliest next AW handshake is the cycle after B completes.
  - An AWSIZE != 3 or AWBURST != 1 at handshake sets err_flags[2]; the burst is processed as a 64-bit INCR burst.
- Read FSM: R_IDLE -> R_DATA -> R_IDLE.
  - R_IDLE: ARREADY=1. An AR handshake latches idx and ARLEN and goes to R_DATA.
  - R_DATA: RVALID is asserted the cycle after the AR handshake, with RDATA = mem[idx].
    - On each RVALID&&RREADY the next word is presented in the following cycle, so beats are back-to-back while RREADY is held high.
    - RLAST=1 exactly on beat ARLEN.
    - While RVALID=1 && RREADY=0, RDATA and RLAST hold stable.
    - After the last beat handshake, RVALID drops and the FSM returns to R_IDLE. Earliest next AR is the following cycle.
  - An ARSIZE/ARBURST violation sets err_flags[2].
- Simultaneous read and write to the same word in the same cycle: the read returns the old data.
- Reset mid-burst: both FSMs return to IDLE next cycle and all outputs go to their reset values. A partial write remains in memory.
- err_flags clear only on rst.

Optional Feature:
- AXI_SLV_BACKPRESSURE_EN defined:
  - A 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 on rst) advances every cycle.
  - WREADY in W_DATA is gated by lfsr[0].
  - Launch of the next RVALID beat is gated by lfsr[1]; an asserted RVALID is never withdrawn before handshake.
  - BVALID assertion is delayed until lfsr[2]=1.
- AXI_SLV_BACKPRESSURE_EN undefined: the zero-stall behaviour above applies, with no LFSR logic present.

Test Plan:
- AW addr=BASE_ADDR, AWLEN=15, 16 beats of WDATA=i, WSTRB=8'hFF, BREADY=1 -> mem[0..15]=0..15; BVALID exactly 1 cycle after the WLAST beat; err_flags=0.
- AR addr=BASE_ADDR, ARLEN=15, RREADY=1 -> RVALID 1 cycle after AR; 16 consecutive beats 0..15; RLAST only on beat 15.
- Write WDATA=64'hFFFF_FFFF_FFFF_FFFF with WSTRB=8'h0F over word 64'h0 -> read back 64'h0000_0000_FFFF_FFFF.
- AWLEN=3 with WLAST asserted on beat 1 -> err_flags[0]=1; BVALID issued; the next burst is accepted normally.
- AR at BASE_ADDR + (2^DEPTH_LOG2 - 2)*8, ARLEN=3 -> data from words 2^DEPTH_LOG2-2, 2^DEPTH_LOG2-1, 0, 1; err_flags[3]=0.
- Assert rst during beat 5 of a 16-beat read with RREADY toggling -> next cycle RVALID=0 and ARREADY=1; a fresh AR returns correct data.

Source files
------------

// File: rtl/axi4_frame_mem_slave_if.sv
// AXI4 write/read channel bundle between a burst master and axi4_frame_mem_slave.
interface axi4_frame_mem_slave_if;
    logic [31:0] AWADDR;
    logic        AWVALID;
    logic        AWREADY;
    logic [7:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST;
    logic [63:0] WDATA;
    logic [7:0]  WSTRB;
    logic        WVALID;
    logic        WREADY;
    logic        WLAST;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [31:0] ARADDR;
    logic        ARVALID;
    logic        ARREADY;
    logic [7:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic [63:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY;
    logic        RLAST;

    modport master (
        output AWADDR, AWVALID, AWLEN, AWSIZE, AWBURST,
        output WDATA, WSTRB, WVALID, WLAST, BREADY,
        output ARADDR, ARVALID, ARLEN, ARSIZE, ARBURST, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID,
        input  ARREADY, RDATA, RRESP, RVALID, RLAST
    );

    modport slave (
        input  AWADDR, AWVALID, AWLEN, AWSIZE, AWBURST,
        input  WDATA, WSTRB, WVALID, WLAST, BREADY,
        input  ARADDR, ARVALID, ARLEN, ARSIZE, ARBURST, RREADY,
        output AWREADY, WREADY, BRESP, BVALID,
        output ARREADY, RDATA, RRESP, RVALID, RLAST
    );
endinterface

// File: rtl/axi4_frame_mem_slave.sv
// AXI4 slave backed by a 64-bit dual-port word memory; independent write and read FSMs.
// Define AXI_SLV_BACKPRESSURE_EN to add LFSR-driven stalls on WREADY, R beat launch and BVALID.
module axi4_frame_mem_slave #(
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int          DEPTH_LOG2 = 14,
    parameter logic [63:0] INIT_VAL   = 64'h0
) (
    input  logic                 clk_100Mhz,
    input  logic                 rst,
    axi4_frame_mem_slave_if.slave axi,
    output logic [3:0]           err_flags
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    // Contents come from configuration only; rst never touches the array.
    logic [63:0] r_mem [DEPTH] = '{default: INIT_VAL};

    wstate_t               r_wstate;
    rstate_t               r_rstate;
    logic                  r_awready, r_wready, r_bvalid;
    logic                  r_arready, r_rvalid, r_rlast;
    logic [63:0]           r_rdata;
    logic [DEPTH_LOG2-1:0] r_widx, r_ridx;
    logic [7:0]            r_wlen, r_wcnt, r_rlen, r_rcnt;
    logic [3:0]            r_err;

    logic                  w_w_go, w_r_go, w_b_go;
    logic                  w_wready, w_wbeat, w_aw_hs, w_ar_hs;
    logic [31:0]           w_aw_word, w_ar_word;
    logic [DEPTH_LOG2-1:0] w_aw_idx, w_ar_idx;
    logic                  w_aw_oor, w_ar_oor, w_aw_bad, w_ar_bad;

`ifdef AXI_SLV_BACKPRESSURE_EN
    logic [15:0] r_lfsr;

    always_ff @(posedge clk_100Mhz) begin
        if (rst) r_lfsr <= 16'hACE1;
        else     r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end

    assign w_w_go = r_lfsr[0];
    assign w_r_go = r_lfsr[1];
    assign w_b_go = r_lfsr[2];
`else
    assign w_w_go = 1'b1;
    assign w_r_go = 1'b1;
    assign w_b_go = 1'b1;
`endif

    // Word index wraps modulo depth; anything outside the window is flagged but still served.
    assign w_aw_word = (axi.AWADDR - BASE_ADDR) >> 3;
    assign w_ar_word = (axi.ARADDR - BASE_ADDR) >> 3;
    assign w_aw_idx  = w_aw_word[DEPTH_LOG2-1:0];
    assign w_ar_idx  = w_ar_word[DEPTH_LOG2-1:0];
    assign w_aw_oor  = (axi.AWADDR < BASE_ADDR) || ((w_aw_word >> DEPTH_LOG2) != 32'd0);
    assign w_ar_oor  = (axi.ARADDR < BASE_ADDR) || ((w_ar_word >> DEPTH_LOG2) != 32'd0);
    assign w_aw_bad  = (axi.AWSIZE != 3'b011) || (axi.AWBURST != 2'b01);
    assign w_ar_bad  = (axi.ARSIZE != 3'b011) || (axi.ARBURST != 2'b01);

    assign w_aw_hs  = axi.AWVALID && r_awready;
    assign w_ar_hs  = axi.ARVALID && r_arready;
    assign w_wready = r_wready && w_w_go;
    assign w_wbeat  = (r_wstate == W_DATA) && axi.WVALID && w_wready;

    assign axi.AWREADY = r_awready;
    assign axi.WREADY  = w_wready;
    assign axi.BVALID  = r_bvalid;
    assign axi.BRESP   = 2'b00;
    assign axi.ARREADY = r_arready;
    assign axi.RVALID  = r_rvalid;
    assign axi.RLAST   = r_rlast;
    assign axi.RDATA   = r_rdata;
    assign axi.RRESP   = 2'b00;
    assign err_flags   = r_err;

    always_ff @(posedge clk_100Mhz) begin
        if (w_wbeat && !rst) begin
            for (int b = 0; b < 8; b++)
                if (axi.WSTRB[b]) r_mem[r_widx][8*b +: 8] <= axi.WDATA[8*b +: 8];
        end
    end

    always_ff @(posedge clk_100Mhz) begin
        if (rst) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b1;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_widx    <= '0;
            r_wlen    <= '0;
            r_wcnt    <= '0;
        end else begin
            case (r_wstate)
                W_IDLE: if (w_aw_hs) begin
                    r_widx    <= w_aw_idx;
                    r_wlen    <= axi.AWLEN;
                    r_wcnt    <= '0;
                    r_awready <= 1'b0;
                    r_wready  <= 1'b1;
                    r_wstate  <= W_DATA;
                end
                W_DATA: if (w_wbeat) begin
                    r_widx <= r_widx + 1'b1;
                    r_wcnt <= r_wcnt + 8'd1;
                    // Early WLAST and missing WLAST both close the burst here.
                    if (axi.WLAST || (r_wcnt == r_wlen)) begin
                        r_wready <= 1'b0;
                        r_bvalid <= w_b_go;
                        r_wstate <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (!r_bvalid && w_b_go) r_bvalid <= 1'b1;
                    if (r_bvalid && axi.BREADY) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    // r_rcnt counts beats already launched; a read racing a write sees the old word.
    always_ff @(posedge clk_100Mhz) begin
        if (rst) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b1;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rdata   <= '0;
            r_ridx    <= '0;
            r_rlen    <= '0;
            r_rcnt    <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: if (w_ar_hs) begin
                    r_rdata   <= r_mem[w_ar_idx];
                    r_rvalid  <= 1'b1;
                    r_rlast   <= (axi.ARLEN == 8'd0);
                    r_ridx    <= w_ar_idx + 1'b1;
                    r_rlen    <= axi.ARLEN;
                    r_rcnt    <= 8'd1;
                    r_arready <= 1'b0;
                    r_rstate  <= R_DATA;
                end
                R_DATA: begin
                    if (r_rvalid && axi.RREADY && r_rlast) begin
                        r_rvalid  <= 1'b0;
                        r_rlast   <= 1'b0;
                        r_arready <= 1'b1;
                        r_rstate  <= R_IDLE;
                    end else if ((!r_rvalid || axi.RREADY) && w_r_go) begin
                        r_rdata  <= r_mem[r_ridx];
                        r_rvalid <= 1'b1;
                        r_rlast  <= (r_rcnt == r_rlen);
                        r_ridx   <= r_ridx + 1'b1;
                        r_rcnt   <= r_rcnt + 8'd1;
                    end else if (r_rvalid && axi.RREADY) begin
                        r_rvalid <= 1'b0;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_100Mhz) begin
        if (rst) begin
            r_err <= '0;
        end else begin
            if (w_aw_hs && w_aw_bad) r_err[2] <= 1'b1;
            if (w_aw_hs && w_aw_oor) r_err[3] <= 1'b1;
            if (w_ar_hs && w_ar_bad) r_err[2] <= 1'b1;
            if (w_ar_hs && w_ar_oor) r_err[3] <= 1'b1;
            if (w_wbeat &&  axi.WLAST && (r_wcnt != r_wlen)) r_err[0] <= 1'b1;
            if (w_wbeat && !axi.WLAST && (r_wcnt == r_wlen)) r_err[1] <= 1'b1;
        end
    end
endmodule
